// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter. It grants the slave port to one master at a time and
// holds the grant for the burst, up to a beat limit. Masters that received a
// SPLIT response stay masked until the slave unsplits them. It also publishes
// the address-phase and data-phase owner indices.
module ahb_slave_arbiter #(
   parameter int MASTER_NUM = 4,
   parameter int ARB_SCHEME = 1,
   parameter int MAX_BEATS  = 16,
   parameter int IDX_W      = $clog2(MASTER_NUM)
) (
   input  logic                  hclk,
   input  logic                  hreset_n,
   input  logic [MASTER_NUM-1:0] hreq,
   input  logic [MASTER_NUM-1:0] hlast,
   input  logic [1:0]            htrans,
   input  logic                  hready,
   input  logic                  split_resp,
   input  logic [MASTER_NUM-1:0] hsplit,
   output logic [MASTER_NUM-1:0] hgrant,
   output logic [IDX_W-1:0]      hmaster,
   output logic [IDX_W-1:0]      hmaster_data,
   output logic                  hbusy
);

   localparam int CNT_W = $clog2(MAX_BEATS) + 1;

   typedef enum logic {
      ARB_IDLE,
      ARB_OWN
   } arb_state_t;

   arb_state_t            state;
   logic [MASTER_NUM-1:0] split_mask;
   logic [MASTER_NUM-1:0] split_set;
   logic [MASTER_NUM-1:0] elig;
   logic [MASTER_NUM-1:0] winner_onehot;
   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      rr_next;
   logic [IDX_W-1:0]      winner;
   logic [IDX_W:0]        cand_sum;
   logic                  winner_found;
   logic [CNT_W-1:0]      beat_cnt;
   logic                  beat;
   logic                  release_evt;
   logic                  unused_htrans0;

   assign unused_htrans0 = htrans[0];
   assign hbusy          = (state == ARB_OWN);

   // The master taking a SPLIT now is excluded from this cycle's arbitration.
   always_comb begin
      split_set = '0;
      if (split_resp) begin
         split_set[hmaster_data] = 1'b1;
      end
      elig = hreq & ~split_mask & ~split_set;
   end

   // Pick the winner: lowest index, or first eligible at/after rr_ptr with wrap.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      cand_sum     = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (ARB_SCHEME == 0) begin
            cand_sum = (IDX_W+1)'(i);
         end else begin
            cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand_sum >= (IDX_W+1)'(MASTER_NUM)) begin
               cand_sum = cand_sum - (IDX_W+1)'(MASTER_NUM);
            end
         end
         if (!winner_found && elig[cand_sum[IDX_W-1:0]]) begin
            winner       = cand_sum[IDX_W-1:0];
            winner_found = 1'b1;
         end
      end
   end

   // Decode the winner to one-hot and work out the pointer after this grant.
   always_comb begin
      winner_onehot         = '0;
      winner_onehot[winner] = 1'b1;
      if (int'(winner) == MASTER_NUM - 1) begin
         rr_next = '0;
      end else begin
         rr_next = winner + 1'b1;
      end
   end

   // Decide whether the current tenure ends this cycle.
   always_comb begin
      beat        = hready && htrans[1];
      release_evt = (beat && hlast[hmaster])
                 || (hready && !hreq[hmaster])
                 || (beat && (beat_cnt == CNT_W'(MAX_BEATS - 1)))
                 || split_resp;
   end

   // Arbitration FSM with registered grant, owner index, pointer and beat count.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state    <= ARB_IDLE;
         hgrant   <= '0;
         hmaster  <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (winner_found) begin
                  state    <= ARB_OWN;
                  hgrant   <= winner_onehot;
                  hmaster  <= winner;
                  rr_ptr   <= rr_next;
                  beat_cnt <= '0;
               end else begin
                  hgrant <= '0;
               end
            end
            ARB_OWN: begin
               if (release_evt) begin
                  beat_cnt <= '0;
                  if (winner_found) begin
                     hgrant  <= winner_onehot;
                     hmaster <= winner;
                     rr_ptr  <= rr_next;
                  end else begin
                     state  <= ARB_IDLE;
                     hgrant <= '0;
                  end
               end else if (beat && (beat_cnt != '1)) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: begin
               state  <= ARB_IDLE;
               hgrant <= '0;
            end
         endcase
      end
   end

   // Track SPLIT-masked masters; an unsplit in the same cycle as a set wins.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         split_mask <= '0;
      end else begin
         split_mask <= (split_mask | split_set) & ~hsplit;
      end
   end

   // Data-phase owner follows the address-phase owner on each completed cycle.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         hmaster_data <= '0;
      end else if (hready) begin
         hmaster_data <= hmaster;
      end
   end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Testbench for ahb_slave_arbiter: a fixed-priority instance (16-beat limit)
// and a round-robin instance (4-beat limit) share one stimulus bus. Table
// vectors feed an expected-value queue that is checked after each clock edge.
module tb_ahb_slave_arbiter;

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_BUSY = 2'd1;
   localparam logic [1:0] T_NSEQ = 2'd2;
   localparam logic [1:0] T_SEQ  = 2'd3;

   typedef struct {
      logic [3:0] hreq;
      logic [3:0] hlast;
      logic [1:0] htrans;
      logic       hready;
      logic       split_resp;
      logic [3:0] hsplit;
      logic [3:0] exp_grant;
      logic [1:0] exp_master;
      logic [1:0] exp_mdata;
      logic       exp_busy;
   } vec_t;

   logic       hclk = 1'b0;
   logic       hreset_n = 1'b0;
   logic [3:0] hreq = '0;
   logic [3:0] hlast = '0;
   logic [1:0] htrans = T_IDLE;
   logic       hready = 1'b1;
   logic       split_resp = 1'b0;
   logic [3:0] hsplit = '0;

   logic [3:0] fp_hgrant, rr_hgrant;
   logic [1:0] fp_hmaster, rr_hmaster, fp_hmaster_data, rr_hmaster_data;
   logic       fp_hbusy, rr_hbusy;

   vec_t  fp_vecs[$];
   vec_t  rr_vecs[$];
   vec_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    step = 0;
   logic  use_rr = 1'b0;
   string scen = "reset";

   always #5 hclk = ~hclk;

   ahb_slave_arbiter #(.MASTER_NUM(4), .ARB_SCHEME(0), .MAX_BEATS(16)) u_fp (
      .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlast(hlast),
      .htrans(htrans), .hready(hready), .split_resp(split_resp), .hsplit(hsplit),
      .hgrant(fp_hgrant), .hmaster(fp_hmaster), .hmaster_data(fp_hmaster_data),
      .hbusy(fp_hbusy)
   );

   ahb_slave_arbiter #(.MASTER_NUM(4), .ARB_SCHEME(1), .MAX_BEATS(4)) u_rr (
      .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlast(hlast),
      .htrans(htrans), .hready(hready), .split_resp(split_resp), .hsplit(hsplit),
      .hgrant(rr_hgrant), .hmaster(rr_hmaster), .hmaster_data(rr_hmaster_data),
      .hbusy(rr_hbusy)
   );

   function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] lst,
                               input logic [1:0] tr, input logic rdy,
                               input logic spl, input logic [3:0] uns,
                               input logic [3:0] g, input logic [1:0] m,
                               input logic [1:0] d, input logic b);
      vec_t v;
      v.hreq = rq; v.hlast = lst; v.htrans = tr; v.hready = rdy;
      v.split_resp = spl; v.hsplit = uns;
      v.exp_grant = g; v.exp_master = m; v.exp_mdata = d; v.exp_busy = b;
      return v;
   endfunction

   task automatic checkField(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic checkOutput();
      vec_t       e;
      logic [3:0] g;
      logic [1:0] m;
      logic [1:0] d;
      logic       b;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s[%0d].scoreboard: got empty queue, expected an entry", scen, step);
         return;
      end
      e = exp_q.pop_front();
      if (use_rr) begin
         g = rr_hgrant; m = rr_hmaster; d = rr_hmaster_data; b = rr_hbusy;
      end else begin
         g = fp_hgrant; m = fp_hmaster; d = fp_hmaster_data; b = fp_hbusy;
      end
      checkField($sformatf("%s[%0d].hgrant", scen, step), {4'b0, g}, {4'b0, e.exp_grant});
      checkField($sformatf("%s[%0d].hmaster", scen, step), {6'b0, m}, {6'b0, e.exp_master});
      checkField($sformatf("%s[%0d].hmaster_data", scen, step), {6'b0, d}, {6'b0, e.exp_mdata});
      checkField($sformatf("%s[%0d].hbusy", scen, step), {7'b0, b}, {7'b0, e.exp_busy});
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge hclk);
      hreq       = v.hreq;
      hlast      = v.hlast;
      htrans     = v.htrans;
      hready     = v.hready;
      split_resp = v.split_resp;
      hsplit     = v.hsplit;
      exp_q.push_back(v);
      @(posedge hclk);
      #1;
      checkOutput();
   endtask

   task automatic doReset();
      hreset_n   = 1'b0;
      hreq       = '0;
      hlast      = '0;
      htrans     = T_IDLE;
      hready     = 1'b1;
      split_resp = 1'b0;
      hsplit     = '0;
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      hreset_n = 1'b1;
      #1;
      checkField("reset.fp_hgrant", {4'b0, fp_hgrant}, 8'h0);
      checkField("reset.fp_hbusy", {7'b0, fp_hbusy}, 8'h0);
      checkField("reset.rr_hgrant", {4'b0, rr_hgrant}, 8'h0);
      checkField("reset.rr_hmaster_data", {6'b0, rr_hmaster_data}, 8'h0);
   endtask

   initial begin
      fp_vecs.push_back(mk(4'b1010, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0010, 1, 0, 1));
      fp_vecs.push_back(mk(4'b1010, 4'b0000, T_NSEQ, 1, 0, 4'b0000, 4'b0010, 1, 1, 1));
      fp_vecs.push_back(mk(4'b1010, 4'b0000, T_SEQ,  1, 0, 4'b0000, 4'b0010, 1, 1, 1));
      fp_vecs.push_back(mk(4'b1010, 4'b0000, T_SEQ,  1, 0, 4'b0000, 4'b0010, 1, 1, 1));
      fp_vecs.push_back(mk(4'b1000, 4'b0010, T_SEQ,  1, 0, 4'b0000, 4'b1000, 3, 1, 1));
      fp_vecs.push_back(mk(4'b1000, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b1000, 3, 3, 1));
      fp_vecs.push_back(mk(4'b0000, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0000, 3, 3, 0));
      fp_vecs.push_back(mk(4'b0010, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0010, 1, 3, 1));
      for (int i = 0; i < 3; i++)
         fp_vecs.push_back(mk(4'b1000, 4'b0010, T_NSEQ, 0, 0, 4'b0000, 4'b0010, 1, 3, 1));
      fp_vecs.push_back(mk(4'b1000, 4'b0010, T_NSEQ, 1, 0, 4'b0000, 4'b1000, 3, 1, 1));
      fp_vecs.push_back(mk(4'b1000, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b1000, 3, 3, 1));
      fp_vecs.push_back(mk(4'b0000, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0000, 3, 3, 0));

      rr_vecs.push_back(mk(4'b1111, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0001, 0, 0, 1));
      rr_vecs.push_back(mk(4'b1111, 4'b1111, T_NSEQ, 1, 0, 4'b0000, 4'b0010, 1, 0, 1));
      rr_vecs.push_back(mk(4'b1111, 4'b1111, T_NSEQ, 1, 0, 4'b0000, 4'b0100, 2, 1, 1));
      rr_vecs.push_back(mk(4'b1111, 4'b1111, T_NSEQ, 1, 0, 4'b0000, 4'b1000, 3, 2, 1));
      rr_vecs.push_back(mk(4'b1111, 4'b1111, T_NSEQ, 1, 0, 4'b0000, 4'b0001, 0, 3, 1));
      rr_vecs.push_back(mk(4'b0001, 4'b1111, T_NSEQ, 1, 0, 4'b0000, 4'b0001, 0, 0, 1));
      rr_vecs.push_back(mk(4'b0001, 4'b1111, T_NSEQ, 1, 0, 4'b0000, 4'b0001, 0, 0, 1));
      rr_vecs.push_back(mk(4'b0100, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0100, 2, 0, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0000, T_NSEQ, 1, 0, 4'b0000, 4'b0100, 2, 2, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0000, T_SEQ,  1, 0, 4'b0000, 4'b0100, 2, 2, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0000, T_SEQ,  1, 0, 4'b0000, 4'b0100, 2, 2, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0000, T_SEQ,  1, 0, 4'b0000, 4'b0001, 0, 2, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0001, T_NSEQ, 1, 0, 4'b0000, 4'b0100, 2, 0, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0000, T_NSEQ, 1, 0, 4'b0000, 4'b0100, 2, 2, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0000, T_BUSY, 1, 0, 4'b0000, 4'b0100, 2, 2, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0000, T_SEQ,  1, 0, 4'b0000, 4'b0100, 2, 2, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0000, T_SEQ,  1, 0, 4'b0000, 4'b0100, 2, 2, 1));
      rr_vecs.push_back(mk(4'b0101, 4'b0000, T_SEQ,  1, 0, 4'b0000, 4'b0001, 0, 2, 1));
      rr_vecs.push_back(mk(4'b0000, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0000, 0, 0, 0));
      rr_vecs.push_back(mk(4'b1000, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b1000, 3, 0, 1));
      rr_vecs.push_back(mk(4'b1001, 4'b0000, T_NSEQ, 1, 0, 4'b0000, 4'b1000, 3, 3, 1));
      rr_vecs.push_back(mk(4'b1001, 4'b0000, T_SEQ,  0, 1, 4'b0000, 4'b0001, 0, 3, 1));
      rr_vecs.push_back(mk(4'b1001, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0001, 0, 0, 1));
      rr_vecs.push_back(mk(4'b1001, 4'b0001, T_NSEQ, 1, 0, 4'b0000, 4'b0001, 0, 0, 1));
      rr_vecs.push_back(mk(4'b1001, 4'b0000, T_IDLE, 1, 0, 4'b1000, 4'b0001, 0, 0, 1));
      rr_vecs.push_back(mk(4'b1001, 4'b0001, T_NSEQ, 1, 0, 4'b0000, 4'b1000, 3, 0, 1));
      rr_vecs.push_back(mk(4'b1001, 4'b0000, T_NSEQ, 1, 0, 4'b0000, 4'b1000, 3, 3, 1));
      rr_vecs.push_back(mk(4'b1001, 4'b0000, T_SEQ,  0, 1, 4'b1000, 4'b0001, 0, 3, 1));
      rr_vecs.push_back(mk(4'b1001, 4'b0001, T_NSEQ, 1, 0, 4'b0000, 4'b1000, 3, 0, 1));
      rr_vecs.push_back(mk(4'b1000, 4'b0000, T_NSEQ, 1, 0, 4'b0000, 4'b1000, 3, 3, 1));
      rr_vecs.push_back(mk(4'b1000, 4'b0000, T_SEQ,  0, 1, 4'b0000, 4'b0000, 3, 3, 0));
      rr_vecs.push_back(mk(4'b1000, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0000, 3, 3, 0));
      rr_vecs.push_back(mk(4'b1000, 4'b0000, T_IDLE, 1, 0, 4'b1000, 4'b0000, 3, 3, 0));
      rr_vecs.push_back(mk(4'b1000, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b1000, 3, 3, 1));
      rr_vecs.push_back(mk(4'b0000, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0000, 3, 3, 0));

      doReset();
      use_rr = 1'b0;
      scen   = "fixed";
      foreach (fp_vecs[i]) begin
         step = i;
         applyStimulus(fp_vecs[i]);
      end

      doReset();
      use_rr = 1'b1;
      scen   = "rrobin";
      foreach (rr_vecs[i]) begin
         step = i;
         applyStimulus(rr_vecs[i]);
      end

      doReset();
      use_rr = 1'b0;
      scen   = "midreset";
      step   = 0;
      applyStimulus(mk(4'b0100, 4'b0000, T_IDLE, 1, 0, 4'b0000, 4'b0100, 2, 0, 1));
      for (int i = 0; i < 5; i++) begin
         step = i + 1;
         applyStimulus(mk(4'b0100, 4'b0000, (i == 0) ? T_NSEQ : T_SEQ, 1, 0, 4'b0000,
                          4'b0100, 2, 2, 1));
      end
      checkField("midreset.beat_cnt", {3'b0, u_fp.beat_cnt}, 8'd5);
      #3;
      hreset_n = 1'b0;
      #1;
      checkField("midreset.async_hgrant", {4'b0, fp_hgrant}, 8'h0);
      checkField("midreset.async_hmaster", {6'b0, fp_hmaster}, 8'h0);
      checkField("midreset.async_hmaster_data", {6'b0, fp_hmaster_data}, 8'h0);
      checkField("midreset.async_hbusy", {7'b0, fp_hbusy}, 8'h0);
      checkField("midreset.async_beat_cnt", {3'b0, u_fp.beat_cnt}, 8'h0);
      hreq   = 4'b0100;
      htrans = T_IDLE;
      #2;
      hreset_n = 1'b1;
      #1;
      checkField("midreset.pre_edge_hgrant", {4'b0, fp_hgrant}, 8'h0);
      @(posedge hclk);
      #1;
      checkField("midreset.regrant_hgrant", {4'b0, fp_hgrant}, 8'h04);
      checkField("midreset.regrant_hmaster", {6'b0, fp_hmaster}, 8'h02);
      checkField("midreset.regrant_hbusy", {7'b0, fp_hbusy}, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Per-slave arbiter for the AHB_Gen multi-master interconnect. It takes the `hreq` vectors that each master-side decoder raises for this slave and grants the slave port to exactly one master at a time. It holds the grant for the full burst, up to a beat limit, and masks masters that received a SPLIT response until the slave unsplits them. It also publishes the address-phase and data-phase owner indices used by the slave-side address/control and write-data muxes.

## Interface
Parameters:
- `MASTER_NUM`, 4: number of masters competing for this slave (2..16).
- `ARB_SCHEME`, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `MAX_BEATS`, 16: maximum transfer beats per tenure before forced re-arbitration (2..256).
- `IDX_W`, `$clog2(MASTER_NUM)`: width of the master index.

Ports:
- `hclk` in 1: clock.
- `hreset_n` in 1: reset, asynchronous, active-low.
- `hreq` in MASTER_NUM: per-master request for this slave (from decoders).
- `hlast` in MASTER_NUM: per-master last-beat-of-burst flag, valid with address phase.
- `htrans` in 2: transfer type of the currently granted master (post-mux). IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hready` in 1: slave HREADY.
- `split_resp` in 1: slave is driving the first SPLIT cycle (hready=0) for the data-phase master.
- `hsplit` in MASTER_NUM: slave unsplit vector, one-cycle pulses.
- `hgrant` out MASTER_NUM: one-hot grant, registered.
- `hmaster` out IDX_W: address-phase owner index.
- `hmaster_data` out IDX_W: data-phase owner index.
- `hbusy` out 1: a tenure is in progress.

## Operation
- Eligible set: `elig = hreq & ~split_mask`.
- Winner:
  - ARB_SCHEME=0: lowest set bit of `elig`.
  - ARB_SCHEME=1: first set bit at or after `rr_ptr`, searching upward with wrap. `rr_ptr` becomes winner+1 (mod MASTER_NUM) on every new grant.
- FSM states are ARB_IDLE and ARB_OWN.
- ARB_IDLE:
  - `hgrant`=0.
  - If `elig`≠0, register the winner into `hgrant`/`hmaster`, clear `beat_cnt`, go to ARB_OWN.
- ARB_OWN: the owner is `hmaster`. A beat is `hready && htrans[1]`, and each beat increments `beat_cnt`. A release event is any of:
  - (a) `hready && htrans[1] && hlast[hmaster]`
  - (b) `hready && !hreq[hmaster]`
  - (c) a beat while `beat_cnt == MAX_BEATS-1`
  - (d) `split_resp`; this condition is independent of `hready`.
- On release:
  - Re-arbitrate the same cycle using `elig`.
  - Under (d), the just-set mask bit is excluded from `elig`.
  - Under (a)–(c) the current owner stays eligible. Round-robin naturally rotates it away.
  - If a winner exists, register it and stay in ARB_OWN with `beat_cnt` cleared. Otherwise go to ARB_IDLE.
- Fixed priority never preempts mid-burst. A higher-priority request waits for a release event.
- `split_mask[i]`:
  - Set when `split_resp` is asserted and `hmaster_data==i`.
  - Cleared when `hsplit[i]` is asserted.
  - If set and clear hit the same bit in the same cycle, clear wins.
- `hmaster_data <= hmaster` whenever `hready==1`. It holds while `hready==0`.
- `hbusy` = (state==ARB_OWN).
- `beat_cnt` width is `$clog2(MAX_BEATS)+1`. It saturates and never wraps.

## Timing
- Reset values: `hgrant`=0, `hmaster`=0, `hmaster_data`=0, `hbusy`=0, `split_mask`=0, `rr_ptr`=0, `beat_cnt`=0, state=ARB_IDLE.
- Reset asserted mid-tenure clears everything immediately and asynchronously. No handover cycle is produced.
- Request to grant latency is 1 cycle from ARB_IDLE: `hreq` sampled at edge N produces `hgrant` valid after edge N.
- Handover:
  - A release at edge N moves the new `hgrant` and `hmaster` after edge N. There is no dead cycle when `elig`≠0.
  - `hmaster_data` follows one `hready` cycle later.
- Split: `split_resp` at edge N drops the grant and sets the mask after edge N. The masked master is eligible again from edge M+1, where `hsplit` is asserted at edge M.
- All masters masked with requests pending: remain in or enter ARB_IDLE. `hgrant`=0.
- `htrans`=BUSY or IDLE does not count as a beat. The grant is held while `hreq` stays high.

## Test plan
1. Fixed priority, ARB_SCHEME=0:
   - Stimulus: `hreq`=4'b1010 from ARB_IDLE.
   - Response: `hgrant`=4'b0010 one cycle later, `hmaster`=1.
   - Stimulus: master 1 completes a 4-beat INCR4 with `hlast` on beat 4.
   - Response: `hgrant`=4'b1000 the next cycle, with no idle cycle between grants.
2. Round-robin:
   - Stimulus: `hreq`=4'b1111 held, each master does a single NONSEQ with `hlast`=1 and `hready`=1.
   - Response: grant order is 0,1,2,3,0.
   - Stimulus: `hreq`=4'b0001 only.
   - Response: master 0 is re-granted back-to-back.
3. Beat limit:
   - Stimulus: MAX_BEATS=4, master 2 issues an undefined-length INCR of 10 beats with `hreq`=4'b0101.
   - Response: the grant moves to master 0 after the 4th beat.
   - Stimulus: master 2 still requesting.
   - Response: master 2 is re-granted later and `beat_cnt` restarts at 0.
4. Wait states:
   - Stimulus: `hready`=0 for 3 cycles during master 1's last beat.
   - Response: `hgrant` and `hmaster_data` are held.
   - Response: handover occurs on the edge where `hready`=1.
5. Split:
   - Stimulus: `split_resp` while `hmaster_data`=3, with `hreq`=4'b1001.
   - Response: `split_mask`=4'b1000 and `hgrant`=4'b0001.
   - Stimulus: `hsplit`=4'b1000, with set and clear on the same cycle also exercised.
   - Response: `split_mask`=0 and master 3 becomes eligible the next cycle.
6. Reset mid-burst:
   - Stimulus: assert `hreset_n`=0 asynchronously while master 2 owns the port with `beat_cnt`=5.
   - Response: all outputs are 0 immediately.
   - Stimulus: release reset with `hreq`=4'b0100.
   - Response: the grant is issued one cycle after the first active edge.
